// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions.
//   key_len_e   : run-time key-length encodings carried on key_len_i
//   RCON_INIT   : round constant loaded when an expansion starts
//   nk_of/nr_of : key words (Nk) and rounds (Nr) for each key length
//   key_len_ok  : legality of a key length for a given maximum supported key size
//   xtime       : multiply by x in GF(2^8) modulo the AES polynomial
package aes_pkg;

    typedef enum logic [1:0] {
        KeyLen128 = 2'd0,
        KeyLen192 = 2'd1,
        KeyLen256 = 2'd2,
        KeyLenBad = 2'd3
    } key_len_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KeyLen192: return 4'd6;
            KeyLen256: return 4'd8;
            default:   return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KeyLen192: return 4'd12;
            KeyLen256: return 4'd14;
            default:   return 4'd10;
        endcase
    endfunction

    function automatic logic key_len_ok(input logic [1:0] len, input int unsigned max_bits);
        case (len)
            KeyLen128: return max_bits >= 128;
            KeyLen192: return max_bits >= 192;
            KeyLen256: return max_bits >= 256;
            default:   return 1'b0;
        endcase
    endfunction

    // 0x80 -> 0x1B: reduction by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   data_i : input byte
//   data_o : substituted byte
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry for byte 0x00 sits in the top eight bits.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte n lives at bit offset (255 - n) * 8, and 255 - n == ~n.
    assign data_o = SBOX_TABLE[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key schedule producing one expanded word per cycle and
// streaming Nr+1 round keys (round 0 first) over a valid/ready interface.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : begin expansion (sampled in idle only) with key_len_i / key_i
//   key_len_i      : 0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   key_i          : cipher key, MSB-aligned, word 0 in [255:224]
//   busy_o, err_o  : expansion in progress / one-cycle illegal-mode pulse
//   rk_valid_o, rk_ready_i, rk_o, rk_idx_o, rk_last_o : round-key stream
//   done_o         : one-cycle pulse after the final round key transfers
// Build option: define AES_KEY_SCHED_ZEROIZE_EN to wipe key material on completion.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned KEY_MAX_BITS = 256,
    parameter int unsigned RND_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       key_len_i,
    input  logic [255:0]     key_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [127:0]     rk_o,
    output logic [RND_W-1:0] rk_idx_o,
    output logic             rk_last_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        key_w_q [8];
    logic [31:0]        key_w_d [8];
    logic [31:0]        win_q   [8];
    logic [31:0]        win_d   [8];
    logic [31:0]        stage_q [3];
    logic [31:0]        stage_d [3];
    logic [3:0]         nk_q, nk_d, nr_q, nr_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [5:0]         i_q, i_d;
    logic [2:0]         mod_q, mod_d;      // i % Nk without a divider
    logic [127:0]       rk_q, rk_d;
    logic               rk_valid_q, rk_valid_d;
    logic [RND_W-1:0]   rk_idx_q, rk_idx_d;
    logic               rk_last_q, rk_last_d;
    logic               err_q, err_d;

    logic [5:0]         words_total;
    logic               use_key, xfer, stall, gen;
    logic [31:0]        rot_t, sub_in, sub_out, t_word, win_old, new_word;

    assign words_total = {nr_q + 4'd1, 2'b00};
    assign use_key     = {2'b00, nk_q} > i_q;
    assign xfer        = rk_valid_q & rk_ready_i;
    assign stall       = rk_valid_q & ~rk_ready_i;
    assign gen         = (state_q == StRun) & ~stall & (i_q < words_total);

    // w[i-Nk] is the oldest word of the active window.
    assign win_old = win_q[3'(nk_q - 4'd1)];
    assign rot_t   = {win_q[0][23:0], win_q[0][31:24]};
    assign sub_in  = (mod_q == 3'd0) ? rot_t : win_q[0];

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data_i(sub_in[8*b +: 8]),
            .data_o(sub_out[8*b +: 8])
        );
    end

    always_comb begin
        t_word = win_q[0];
        if (mod_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
            t_word = sub_out;
        end
        new_word = use_key ? key_w_q[i_q[2:0]] : (win_old ^ t_word);
    end

    always_comb begin
        state_d    = state_q;
        key_w_d    = key_w_q;
        win_d      = win_q;
        stage_d    = stage_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        rcon_d     = rcon_q;
        i_d        = i_q;
        mod_d      = mod_q;
        rk_d       = rk_q;
        rk_valid_d = rk_valid_q;
        rk_idx_d   = rk_idx_q;
        rk_last_d  = rk_last_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (key_len_ok(key_len_i, KEY_MAX_BITS)) begin
                        for (int k = 0; k < 8; k++) begin
                            key_w_d[k] = key_i[255 - 32*k -: 32];
                        end
                        nk_d    = nk_of(key_len_i);
                        nr_d    = nr_of(key_len_i);
                        rcon_d  = RCON_INIT;
                        i_d     = '0;
                        mod_d   = '0;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    rk_valid_d = 1'b0;
                    if (rk_last_q) begin
                        state_d = StDone;
                    end
                end
                if (gen) begin
                    win_d[0] = new_word;
                    for (int k = 1; k < 8; k++) begin
                        win_d[k] = win_q[k-1];
                    end
                    i_d   = i_q + 6'd1;
                    mod_d = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
                    if (!use_key && mod_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    // Fourth word of a group completes a round key; it may land on the
                    // same edge the previous key transfers.
                    if (i_q[1:0] == 2'd3) begin
                        rk_d       = {stage_q[0], stage_q[1], stage_q[2], new_word};
                        rk_valid_d = 1'b1;
                        rk_idx_d   = RND_W'(i_q[5:2]);
                        rk_last_d  = (i_q[5:2] == nr_q);
                    end else begin
                        stage_d[i_q[1:0]] = new_word;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
                for (int k = 0; k < 8; k++) begin
                    key_w_d[k] = '0;
                    win_d[k]   = '0;
                end
                for (int k = 0; k < 3; k++) begin
                    stage_d[k] = '0;
                end
                rk_d = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int k = 0; k < 8; k++) begin
                key_w_q[k] <= '0;
                win_q[k]   <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                stage_q[k] <= '0;
            end
            nk_q       <= '0;
            nr_q       <= '0;
            rcon_q     <= '0;
            i_q        <= '0;
            mod_q      <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_w_q    <= key_w_d;
            win_q      <= win_d;
            stage_q    <= stage_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            rcon_q     <= rcon_d;
            i_q        <= i_d;
            mod_q      <= mod_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
            rk_last_q  <= rk_last_d;
            err_q      <= err_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_o       = rk_q;
    assign rk_idx_o   = rk_idx_q;
    assign rk_last_o  = rk_last_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 key-expansion vectors.
module tb_aes_key_sched;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK0_128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK0_192  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] RK1_192  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK0_256  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] RK1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   key_len_i;
    logic [255:0] key_i;
    logic         rk_ready_i;
    logic         busy_o, err_o, rk_valid_o, rk_last_o, done_o;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx_o;

    // Second instance limited to AES-128 for the unsupported-mode check.
    logic         start_b;
    logic [1:0]   key_len_b;
    logic         b_busy, b_err, b_valid, b_last, b_done;
    logic [127:0] b_rk;
    logic [3:0]   b_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] got_rk   [16];
    logic [3:0]   got_idx  [16];
    logic         got_last [16];
    int           got_cyc  [16];
    int           n_got, done_at, stall_bad, err_seen;
    logic         busy_first;

    always #5 clk = ~clk;

    aes_key_sched #(.KEY_MAX_BITS(256), .RND_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .key_len_i(key_len_i), .key_i(key_i),
        .busy_o(busy_o), .err_o(err_o), .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i),
        .rk_o(rk_o), .rk_idx_o(rk_idx_o), .rk_last_o(rk_last_o), .done_o(done_o)
    );

    aes_key_sched #(.KEY_MAX_BITS(128), .RND_W(4)) dut128 (
        .clk(clk), .rst(rst), .start_i(start_b), .key_len_i(key_len_b), .key_i(key_i),
        .busy_o(b_busy), .err_o(b_err), .rk_valid_o(b_valid), .rk_ready_i(rk_ready_i),
        .rk_o(b_rk), .rk_idx_o(b_idx), .rk_last_o(b_last), .done_o(b_done)
    );

    task automatic do_start(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        start_i    = 1'b1;
        key_len_i  = len;
        key_i      = key;
        rk_ready_i = 1'b1;
    endtask

    // Cycle c is the falling edge after rising edge c-1; start is taken at edge 0.
    task automatic collect(input bit rnd, input int inject_at, input int budget);
        logic         prev_stall = 1'b0;
        logic [127:0] prev_rk = '0;
        logic [3:0]   prev_idx = '0;
        logic         prev_last = 1'b0;
        n_got = 0; done_at = -1; stall_bad = 0; err_seen = 0;
        for (int k = 0; k < 16; k++) begin
            got_rk[k] = '0; got_idx[k] = '0; got_last[k] = 1'b0; got_cyc[k] = 0;
        end
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_i    = 1'b0;
                busy_first = busy_o;
            end
            if (c == inject_at) begin
                start_i   = 1'b1;
                key_len_i = 2'd3;
                key_i     = '1;
            end else if (c == inject_at + 1) begin
                start_i = 1'b0;
            end
            if (err_o) err_seen++;
            if (prev_stall && (rk_valid_o !== 1'b1 || rk_o !== prev_rk ||
                               rk_idx_o !== prev_idx || rk_last_o !== prev_last)) stall_bad++;
            if (done_o) begin
                done_at = c;
                break;
            end
            rk_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid_o && rk_ready_i) begin
                if (n_got < 16) begin
                    got_rk[n_got]   = rk_o;
                    got_idx[n_got]  = rk_idx_o;
                    got_last[n_got] = rk_last_o;
                    got_cyc[n_got]  = c;
                end
                n_got++;
            end
            prev_stall = rk_valid_o && !rk_ready_i;
            prev_rk    = rk_o;
            prev_idx   = rk_idx_o;
            prev_last  = rk_last_o;
        end
        rk_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; start_b = 1'b0; key_len_i = '0; key_len_b = '0;
        key_i = '0; rk_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_o, err_o, rk_valid_o, rk_last_o, done_o} !== 5'b0 || rk_o !== '0 ||
            rk_idx_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b err=%b valid=%b last=%b done=%b rk=%h idx=%0d, need all 0",
                     busy_o, err_o, rk_valid_o, rk_last_o, done_o, rk_o, rk_idx_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_aes128();
        logic [127:0] exp_after;
        do_start(2'd0, K128);
        collect(1'b0, 0, 120);
        n_checks++;
        if (busy_first !== 1'b1) begin
            n_fail++; $display("FAIL a128_busy: got %b need 1", busy_first);
        end
        n_checks++;
        if (n_got != 11) begin n_fail++; $display("FAIL a128_count: got %0d need 11", n_got); end
        n_checks++;
        if (got_rk[0] !== RK0_128) begin
            n_fail++; $display("FAIL a128_rk0: got %h need %h", got_rk[0], RK0_128);
        end
        n_checks++;
        if (got_rk[1] !== RK1_128) begin
            n_fail++; $display("FAIL a128_rk1: got %h need %h", got_rk[1], RK1_128);
        end
        n_checks++;
        if (got_rk[10] !== RK10_128) begin
            n_fail++; $display("FAIL a128_rk10: got %h need %h", got_rk[10], RK10_128);
        end
        for (int r = 0; r <= 10; r++) begin
            n_checks++;
            if (got_idx[r] !== 4'(r) || got_last[r] !== (r == 10)) begin
                n_fail++;
                $display("FAIL a128_idx_last[%0d]: got idx=%0d last=%b need idx=%0d last=%b",
                         r, got_idx[r], got_last[r], r, (r == 10));
            end
        end
        n_checks++;
        if (got_cyc[0] != 5 || got_cyc[10] != 45) begin
            n_fail++;
            $display("FAIL a128_latency: got first=%0d last=%0d need 5 and 45",
                     got_cyc[0], got_cyc[10]);
        end
        n_checks++;
        if (done_at != 46) begin n_fail++; $display("FAIL a128_done: got %0d need 46", done_at); end
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || rk_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL a128_idle_after: got done=%b busy=%b valid=%b need 0 0 0",
                     done_o, busy_o, rk_valid_o);
        end
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        exp_after = '0;
`else
        exp_after = RK10_128;
`endif
        n_checks++;
        if (rk_o !== exp_after) begin
            n_fail++; $display("FAIL a128_rk_after_done: got %h need %h", rk_o, exp_after);
        end
    endtask

    task automatic test_aes256();
        do_start(2'd2, K256);
        collect(1'b0, 0, 120);
        n_checks++;
        if (n_got != 15 || got_rk[0] !== RK0_256 || got_rk[1] !== RK1_256) begin
            n_fail++;
            $display("FAIL a256_head: got n=%0d rk0=%h rk1=%h need 15 %h %h",
                     n_got, got_rk[0], got_rk[1], RK0_256, RK1_256);
        end
        n_checks++;
        if (got_rk[14] !== RK14_256 || got_last[14] !== 1'b1 || got_last[13] !== 1'b0) begin
            n_fail++;
            $display("FAIL a256_rk14: got %h last=%b need %h last=1", got_rk[14], got_last[14],
                     RK14_256);
        end
        n_checks++;
        if (got_cyc[14] != 61 || done_at != 62) begin
            n_fail++;
            $display("FAIL a256_timing: got last=%0d done=%0d need 61 62", got_cyc[14], done_at);
        end
    endtask

    task automatic test_backpressure();
        do_start(2'd2, K256);
        collect(1'b1, 0, 2000);
        n_checks++;
        if (done_at < 0) begin n_fail++; $display("FAIL bp_timeout: got no done, need done"); end
        n_checks++;
        if (n_got != 15) begin n_fail++; $display("FAIL bp_count: got %0d need 15", n_got); end
        n_checks++;
        if (got_rk[0] !== RK0_256 || got_rk[1] !== RK1_256 || got_rk[14] !== RK14_256) begin
            n_fail++;
            $display("FAIL bp_keys: got rk0=%h rk1=%h rk14=%h need %h %h %h", got_rk[0],
                     got_rk[1], got_rk[14], RK0_256, RK1_256, RK14_256);
        end
        for (int r = 0; r < 15; r++) begin
            n_checks++;
            if (got_idx[r] !== 4'(r)) begin
                n_fail++; $display("FAIL bp_idx[%0d]: got %0d need %0d", r, got_idx[r], r);
            end
        end
        n_checks++;
        if (stall_bad != 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d stall changes need 0", stall_bad);
        end
    endtask

    task automatic test_illegal();
        do_start(2'd3, K128);
        @(negedge clk);
        start_i = 1'b0;
        n_checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL ill_pulse: got err=%b busy=%b need 1 0", err_o, busy_o);
        end
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0 || rk_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_after: got err=%b busy=%b valid=%b need 0 0 0", err_o, busy_o,
                     rk_valid_o);
        end
        for (int m = 1; m <= 2; m++) begin
            @(negedge clk);
            start_b = 1'b1; key_len_b = 2'(m);
            @(negedge clk);
            start_b = 1'b0;
            n_checks++;
            if (b_err !== 1'b1 || b_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL max128_mode%0d: got err=%b busy=%b need 1 0", m, b_err, b_busy);
            end
        end
        @(negedge clk);
        start_b = 1'b1; key_len_b = 2'd0; key_i = K128; rk_ready_i = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_checks++;
        if (b_busy !== 1'b1 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL max128_legal: got busy=%b err=%b need 1 0", b_busy, b_err);
        end
        for (int c = 0; c < 100 && b_busy; c++) @(negedge clk);
        n_checks++;
        if (b_busy !== 1'b0) begin n_fail++; $display("FAIL max128_finish: got busy=1 need 0"); end
    endtask

    task automatic test_start_in_run();
        do_start(2'd0, K128);
        collect(1'b0, 10, 120);
        n_checks++;
        if (err_seen != 0) begin
            n_fail++; $display("FAIL run_start_err: got %0d err pulses need 0", err_seen);
        end
        n_checks++;
        if (n_got != 11 || got_rk[10] !== RK10_128 || done_at != 46) begin
            n_fail++;
            $display("FAIL run_start_keys: got n=%0d rk10=%h done=%0d need 11 %h 46",
                     n_got, got_rk[10], done_at, RK10_128);
        end
    endtask

    task automatic test_mid_reset();
        int xfers = 0;
        do_start(2'd0, K128);
        for (int c = 1; c <= 100 && xfers < 3; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (rk_valid_o && rk_ready_i) xfers++;
        end
        n_checks++;
        if (xfers != 3) begin n_fail++; $display("FAIL mr_xfers: got %0d need 3", xfers); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_o, err_o, rk_valid_o, rk_last_o, done_o} !== 5'b0 || rk_o !== '0 ||
            rk_idx_o !== '0) begin
            n_fail++;
            $display("FAIL mr_outputs: got busy=%b valid=%b rk=%h idx=%0d need all 0",
                     busy_o, rk_valid_o, rk_o, rk_idx_o);
        end
        rst = 1'b0;
        do_start(2'd1, K192);
        collect(1'b0, 0, 120);
        n_checks++;
        if (n_got != 13 || got_rk[0] !== RK0_192 || got_rk[1] !== RK1_192) begin
            n_fail++;
            $display("FAIL mr_a192_head: got n=%0d rk0=%h rk1=%h need 13 %h %h", n_got,
                     got_rk[0], got_rk[1], RK0_192, RK1_192);
        end
        n_checks++;
        if (got_rk[12] !== RK12_192 || got_last[12] !== 1'b1 || done_at != 54) begin
            n_fail++;
            $display("FAIL mr_a192_rk12: got %h last=%b done=%0d need %h 1 54", got_rk[12],
                     got_last[12], done_at, RK12_192);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256();
        test_backpressure();
        test_illegal();
        test_start_in_run();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
